// File: rtl/lcd_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_alu_seq_ctrl
//
// Sequences the on-board ALU experiment through the touchscreen LCD
// controller. Three touchscreen beats load SRC_1, SRC_2 and CONTR. The ALU is
// then started with a one-cycle pulse. Its result is captured when alu_done
// arrives, or replaced by all-ones with err set when the wait times out.
// In parallel, the block answers the LCD controller's per-slot display
// requests (5-char name + 32-bit value) with one cycle of latency.
//
// Parameters:
//   OP_W     ALU control word width (1..32)
//   TIMEOUT  max cycles to wait for alu_done after alu_start (1..65535)
//
// Optional feature:
//   LCD_INPUT_ECHO_EN  when defined, adds a last_input register that captures
//                      every touchscreen beat. Slot 7 ("INPUT") shows it.
//
// Ports:
//   clk, reset       system clock; synchronous active-high reset
//   display_number   slot the LCD controller is drawing
//   display_valid    name/value valid for the slot sampled last cycle
//   display_name     5 ASCII chars, first char in the MSBs
//   display_value    value for the slot
//   input_valid      one-cycle touchscreen input beat
//   input_value      touchscreen input data
//   alu_src1/src2    operand registers
//   alu_control      ALU control register
//   alu_start        one-cycle start pulse
//   alu_result       ALU result, valid with alu_done
//   alu_done         one-cycle completion pulse
//   busy             high while waiting on the ALU
//   err              sticky timeout flag, cleared by the next start
// ---------------------------------------------------------------------------
module lcd_alu_seq_ctrl #(
    parameter int OP_W    = 12,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      display_number,
    output logic            display_valid,
    output logic [39:0]     display_name,
    output logic [31:0]     display_value,
    input  logic            input_valid,
    input  logic [31:0]     input_value,
    output logic [31:0]     alu_src1,
    output logic [31:0]     alu_src2,
    output logic [OP_W-1:0] alu_control,
    output logic            alu_start,
    input  logic [31:0]     alu_result,
    input  logic            alu_done,
    output logic            busy,
    output logic            err
);

    // Encodings double as the state code shown on the STATE slot.
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_BUSY = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state, state_next;
    logic [31:0] result;
    logic [31:0] op_count;
    logic [15:0] wait_cnt;

    logic load_src1, load_src2, load_ctrl, start_op, capture, timeout;

    // Next-state and per-cycle action decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_next = state;
        load_src1  = 1'b0;
        load_src2  = 1'b0;
        load_ctrl  = 1'b0;
        start_op   = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_A, S_DONE: if (input_valid) begin
                load_src1  = 1'b1;
                state_next = S_B;
            end
            S_B: if (input_valid) begin
                load_src2  = 1'b1;
                state_next = S_OP;
            end
            S_OP: if (input_valid) begin
                load_ctrl  = 1'b1;
                start_op   = 1'b1;
                state_next = S_BUSY;
            end
            S_BUSY: begin
                // alu_done wins over a timeout in the same cycle. Beats are ignored here.
                if (alu_done) begin
                    capture    = 1'b1;
                    state_next = S_DONE;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    timeout    = 1'b1;
                    state_next = S_DONE;
                end
            end
            default: state_next = S_A;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (reset) state <= S_A;
        else       state <= state_next;
    end

    // Operand, control, result and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_src1    <= '0;
            alu_src2    <= '0;
            alu_control <= '0;
            alu_start   <= 1'b0;
            result      <= '0;
            op_count    <= '0;
            wait_cnt    <= '0;
            err         <= 1'b0;
        end else begin
            // Registered pulse: the start cycle is the first cycle in S_BUSY.
            alu_start <= start_op;
            if (load_src1) alu_src1    <= input_value;
            if (load_src2) alu_src2    <= input_value;
            if (load_ctrl) alu_control <= input_value[OP_W-1:0];

            if (start_op) begin
                err      <= 1'b0;
                wait_cnt <= '0;
            end else if (state == S_BUSY && !capture && !timeout) begin
                wait_cnt <= wait_cnt + 16'd1;
            end

            if (capture) begin
                result   <= alu_result;
                op_count <= op_count + 32'd1;
            end else if (timeout) begin
                result <= 32'hFFFF_FFFF;
                err    <= 1'b1;
            end
        end
    end

    assign busy = (state == S_BUSY);

`ifdef LCD_INPUT_ECHO_EN
    logic [31:0] last_input;

    // Captures every beat, including the ones the FSM ignores in S_BUSY.
    always_ff @(posedge clk) begin
        if (reset)            last_input <= '0;
        else if (input_valid) last_input <= input_value;
    end
`endif

    // Display path. Slots outside the map drop valid but keep name/value.
    always_ff @(posedge clk) begin
        if (reset) begin
            display_valid <= 1'b0;
            display_name  <= '0;
            display_value <= '0;
        end else begin
            display_valid <= 1'b1;
            case (display_number)
                6'd1: begin
                    display_name  <= 40'h53_52_43_5F_31;  // SRC_1
                    display_value <= alu_src1;
                end
                6'd2: begin
                    display_name  <= 40'h53_52_43_5F_32;  // SRC_2
                    display_value <= alu_src2;
                end
                6'd3: begin
                    display_name  <= 40'h43_4F_4E_54_52;  // CONTR
                    display_value <= 32'(alu_control);
                end
                6'd4: begin
                    display_name  <= 40'h52_45_53_55_4C;  // RESUL
                    display_value <= result;
                end
                6'd5: begin
                    display_name  <= 40'h53_54_41_54_45;  // STATE
                    display_value <= {err, 28'b0, state};
                end
                6'd6: begin
                    display_name  <= 40'h43_4F_55_4E_54;  // COUNT
                    display_value <= op_count;
                end
`ifdef LCD_INPUT_ECHO_EN
                6'd7: begin
                    display_name  <= 40'h49_4E_50_55_54;  // INPUT
                    display_value <= last_input;
                end
`endif
                default: display_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/lcd_alu_seq_ctrl.md
Name: lcd_alu_seq_ctrl

Overview:
- Sequences the on-board ALU experiment through the touchscreen LCD controller.
- Loads SRC_1, SRC_2 and CONTR in turn from touchscreen input beats, then starts the ALU and captures its result with a timeout.
- Serves the LCD controller's per-slot display requests (name and value) from internal registers.
- Sits between the LCD controller block and the ALU datapath at board top level.

Parameters:
- OP_W, 12: ALU control word width (1..32).
- TIMEOUT, 255: max cycles to wait for alu_done after alu_start (1..65535).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- display_number  in  6  slot the LCD controller is drawing
- display_valid  out  1  name/value valid for the slot sampled last cycle
- display_name  out  40  5 ASCII chars, MSB = first char
- display_value  out  32  value for the slot
- input_valid  in  1  one-cycle touchscreen input beat
- input_value  in  32  touchscreen input data
- alu_src1  out  32  operand 1 register
- alu_src2  out  32  operand 2 register
- alu_control  out  OP_W  ALU control register
- alu_start  out  1  one-cycle start pulse
- alu_result  in  32  ALU result, valid with alu_done
- alu_done  in  1  one-cycle completion pulse
- busy  out  1  high in S_BUSY
- err  out  1  sticky timeout flag

Behaviour:
- Reset (synchronous, highest priority, aborts any operation):
  - state=S_A; alu_src1, alu_src2, alu_control, result, op_count, wait counter all cleared.
  - alu_start=0, display_valid=0, display_name=0, display_value=0, err=0, busy=0.
- FSM states: S_A, S_B, S_OP, S_BUSY, S_DONE.
- S_A, on input_valid: alu_src1<=input_value; ->S_B.
- S_B, on input_valid: alu_src2<=input_value; ->S_OP.
- S_OP, on input_valid:
  - alu_control<=input_value[OP_W-1:0]; upper bits ignored.
  - alu_start=1 on the next cycle for exactly 1 cycle; err<=0; wait counter<=0; ->S_BUSY.
- S_BUSY:
  - Wait counter increments each cycle after the alu_start cycle.
  - alu_done=1 (including in the alu_start cycle): result<=alu_result; op_count<=op_count+1 (wraps at 2^32); ->S_DONE.
  - Else if counter==TIMEOUT: result<=32'hFFFF_FFFF; err<=1; op_count unchanged; ->S_DONE.
  - alu_done has priority over timeout in the same cycle.
  - input_valid is ignored, including when it coincides with alu_done.
- S_DONE, on input_valid: alu_src1<=input_value; ->S_B. Starts a new operation; result and err hold until the next start.
- alu_done outside S_BUSY is ignored.
- Display path, 1-cycle latency:
  - display_number is sampled every cycle; outputs are registered next cycle from the register contents at the sample edge.
  - 1: "SRC_1", alu_src1.
  - 2: "SRC_2", alu_src2.
  - 3: "CONTR", alu_control zero-extended to 32 bits.
  - 4: "RESUL", result.
  - 5: "STATE", {err, 28'b0, state code S_A=0, S_B=1, S_OP=2, S_BUSY=3, S_DONE=4}; err is bit 31, state code in bits [2:0].
  - 6: "COUNT", op_count.
  - All other numbers, including 0: display_valid=0; name and value hold their previous values.
- A display_number change yields new data exactly 1 cycle later, with no gap cycle.

Optional Feature:
- Macro LCD_INPUT_ECHO_EN.
- Defined:
  - Adds 32-bit last_input register, loaded on every input_valid in any state, including ignored beats in S_BUSY; reset 0.
  - Slot 7 returns "INPUT", last_input with display_valid=1.
- Undefined: no register; slot 7 behaves as an unused slot (display_valid=0).

Test Plan:
- Reset, then display_number=1 -> next cycle display_valid=1, display_name=40'h53_52_43_5F_31 ("SRC_1"), display_value=0; display_number=0 -> display_valid=0.
- Input beats 32'h0000_0005, 32'h0000_0003, 32'h0000_0001 -> alu_start pulses once, 1 cycle after the third beat; alu_done with alu_result=32'h8 three cycles later -> slot 4 reads 8, slot 6 reads 1, slot 5 reads state code 4.
- Start an operation and never assert alu_done -> after TIMEOUT (255) counted cycles: err=1, slot 4 reads 32'hFFFF_FFFF, slot 5 reads 32'h8000_0004, op_count unchanged; the next operation's start clears err.
- In S_BUSY, assert input_valid together with alu_done -> result captured, alu_src1 unchanged, state S_DONE.
- Assert reset during S_BUSY -> next cycle state S_A, alu_start=0, all registers 0, a later alu_done ignored.
- With LCD_INPUT_ECHO_EN: input beat 32'hCAFE_0001 during S_BUSY -> slot 7 returns "INPUT" with value 32'hCAFE_0001; without the macro, slot 7 gives display_valid=0.
